// File: rtl/led_pwm_driver.sv
// Multi-channel LED PWM driver: RGB and single-colour LEDs share one 255-step PWM timebase.
// Define LED_PWM_FADE_EN to ramp shadow duties toward their inputs by at most parm_fade_step per period.
module led_pwm_driver #(
    parameter int unsigned parm_color_led_count = 4,
    parameter int unsigned parm_basic_led_count = 4,
    parameter int unsigned parm_clk_div         = 16,
    parameter int unsigned parm_fade_step       = 1
) (
    input  logic                                i_clk,
    input  logic                                i_srst_n,
    input  logic [8*parm_color_led_count-1:0]   i_color_led_red_value,
    input  logic [8*parm_color_led_count-1:0]   i_color_led_green_value,
    input  logic [8*parm_color_led_count-1:0]   i_color_led_blue_value,
    input  logic [8*parm_basic_led_count-1:0]   i_basic_led_lumin_value,
    output logic [parm_color_led_count-1:0]     eo_color_leds_r,
    output logic [parm_color_led_count-1:0]     eo_color_leds_g,
    output logic [parm_color_led_count-1:0]     eo_color_leds_b,
    output logic [parm_basic_led_count-1:0]     eo_basic_leds_l,
    output logic                                o_period_start
);
    localparam int unsigned C_N     = parm_color_led_count;
    localparam int unsigned CH_N    = 3 * parm_color_led_count + parm_basic_led_count;
    localparam int unsigned PRESC_W = 16;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(parm_clk_div - 1);
    localparam logic [7:0]         CNT_MAX   = 8'd254;

    // Reject illegal configurations at elaboration time.
    if (parm_clk_div == 0 || parm_clk_div > 65535) begin : g_bad_clk_div
        $error("led_pwm_driver: parm_clk_div must be 1..65535");
    end
    if (parm_fade_step == 0 || parm_fade_step > 255) begin : g_bad_fade_step
        $error("led_pwm_driver: parm_fade_step must be 1..255");
    end

    logic [PRESC_W-1:0] presc_q;
    logic [7:0]         cnt_q;
    logic               step_c;
    logic               wrap_c;
    logic [8*CH_N-1:0]  duty_in_c;
    logic [8*CH_N-1:0]  shadow_q;
    logic [8*CH_N-1:0]  shadow_next_c;
    logic [CH_N-1:0]    led_q;

    assign step_c    = (presc_q == PRESC_MAX);
    assign wrap_c    = step_c && (cnt_q == CNT_MAX);
    assign duty_in_c = {i_basic_led_lumin_value, i_color_led_blue_value,
                        i_color_led_green_value, i_color_led_red_value};

    // Per-channel next shadow duty, applied only at the period wrap.
    for (genvar i = 0; i < CH_N; i++) begin : g_ch
`ifdef LED_PWM_FADE_EN
        localparam logic [7:0] FADE_STEP = 8'(parm_fade_step);
        logic [7:0] tgt_c;
        logic [7:0] cur_c;
        logic       up_c;
        logic [7:0] diff_c;
        logic [7:0] amt_c;

        assign tgt_c  = duty_in_c[8*i +: 8];
        assign cur_c  = shadow_q[8*i +: 8];
        assign up_c   = (tgt_c >= cur_c);
        assign diff_c = up_c ? (tgt_c - cur_c) : (cur_c - tgt_c);
        // amt never exceeds the distance, so no overshoot or wrap-around.
        assign amt_c  = (diff_c > FADE_STEP) ? FADE_STEP : diff_c;
        assign shadow_next_c[8*i +: 8] = up_c ? (cur_c + amt_c) : (cur_c - amt_c);
`else
        assign shadow_next_c[8*i +: 8] = duty_in_c[8*i +: 8];
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            led_q          <= '0;
            o_period_start <= 1'b0;
        end else begin
            presc_q <= step_c ? '0 : presc_q + PRESC_W'(1);
            if (step_c) begin
                cnt_q <= (cnt_q == CNT_MAX) ? 8'd0 : cnt_q + 8'd1;
            end
            if (wrap_c) begin
                shadow_q <= shadow_next_c;
            end
            o_period_start <= wrap_c;
            // Counter max is 254, so duty 0xFF is always on and 0x00 always off.
            for (int i = 0; i < CH_N; i++) begin
                led_q[i] <= (cnt_q < shadow_q[8*i +: 8]);
            end
        end
    end

    assign eo_color_leds_r = led_q[C_N-1:0];
    assign eo_color_leds_g = led_q[2*C_N-1:C_N];
    assign eo_color_leds_b = led_q[3*C_N-1:2*C_N];
    assign eo_basic_leds_l = led_q[CH_N-1:3*C_N];

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: two instances (clk_div 1 and 3) against a
// clock-index reference model; fade behaviour follows LED_PWM_FADE_EN.
module tb_led_pwm_driver;
    localparam int unsigned C = 4;
    localparam int unsigned B = 4;
    localparam int unsigned N = 3 * C + B;
    localparam int FADE_STEP = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            srst_n;
    logic [8*C-1:0]  red_v, green_v, blue_v;
    logic [8*B-1:0]  lum_v;
    logic [C-1:0]    r1, g1, b1, r3, g3, b3;
    logic [B-1:0]    l1, l3;
    logic            ps1, ps3;

    int duty [N];
    int k [2];
    int shadow [2][N];
    int divs [2] = '{1, 3};
    int n_checks = 0;
    int n_fail = 0;

    led_pwm_driver #(.parm_clk_div(1), .parm_fade_step(FADE_STEP)) dut1 (
        .i_clk(clk), .i_srst_n(srst_n),
        .i_color_led_red_value(red_v), .i_color_led_green_value(green_v),
        .i_color_led_blue_value(blue_v), .i_basic_led_lumin_value(lum_v),
        .eo_color_leds_r(r1), .eo_color_leds_g(g1), .eo_color_leds_b(b1),
        .eo_basic_leds_l(l1), .o_period_start(ps1)
    );

    led_pwm_driver #(.parm_clk_div(3), .parm_fade_step(FADE_STEP)) dut3 (
        .i_clk(clk), .i_srst_n(srst_n),
        .i_color_led_red_value(red_v), .i_color_led_green_value(green_v),
        .i_color_led_blue_value(blue_v), .i_basic_led_lumin_value(lum_v),
        .eo_color_leds_r(r3), .eo_color_leds_g(g3), .eo_color_leds_b(b3),
        .eo_basic_leds_l(l3), .o_period_start(ps3)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int next_shadow(input int cur, input int tgt);
`ifdef LED_PWM_FADE_EN
        int delta;
        delta = tgt - cur;
        if (delta > FADE_STEP) delta = FADE_STEP;
        if (delta < -FADE_STEP) delta = -FADE_STEP;
        return cur + delta;
`else
        return (cur == tgt) ? cur : tgt;
`endif
    endfunction

    // One clock: drive inputs, predict the post-edge outputs of both instances, compare.
    task automatic tick();
        logic [N-1:0] exp_led [2];
        logic         exp_ps [2];
        int           cnt;
        int           period;
        for (int c = 0; c < C; c++) begin
            red_v[8*c +: 8]   = 8'(duty[c]);
            green_v[8*c +: 8] = 8'(duty[C + c]);
            blue_v[8*c +: 8]  = 8'(duty[2*C + c]);
        end
        for (int b = 0; b < B; b++) lum_v[8*b +: 8] = 8'(duty[3*C + b]);
        for (int d = 0; d < 2; d++) begin
            period = 255 * divs[d];
            if (!srst_n) begin
                k[d] = 0;
                exp_led[d] = '0;
                exp_ps[d] = 1'b0;
                for (int i = 0; i < N; i++) shadow[d][i] = 0;
            end else begin
                cnt = (k[d] / divs[d]) % 255;
                for (int i = 0; i < N; i++) exp_led[d][i] = (cnt < shadow[d][i]);
                k[d]++;
                if (k[d] % period == 0)
                    for (int i = 0; i < N; i++) shadow[d][i] = next_shadow(shadow[d][i], duty[i]);
                exp_ps[d] = (k[d] % period == 0);
            end
        end
        @(posedge clk);
        #1;
        check("leds_div1", {l1, b1, g1, r1}, exp_led[0]);
        check("period_start_div1", ps1, exp_ps[0]);
        check("leds_div3", {l3, b3, g3, r3}, exp_led[1]);
        check("period_start_div3", ps3, exp_ps[1]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int  cnt_t;
        int  high_t;
        bit  seen;

        srst_n = 1'b0;
        for (int i = 0; i < N; i++) duty[i] = 0;
        run(2);
        srst_n = 1'b1;

        // Mixed random duties with the directed channels pinned.
        for (int i = 0; i < N; i++) duty[i] = int'($urandom_range(0, 255));
        duty[0]         = 8'h80;
        duty[1]         = 8'h01;
        duty[C + 1]     = 8'h40;
        duty[3*C + 0]   = 8'h00;
        duty[3*C + 1]   = 8'hFF;
        run(3 * 765);

        // Change green[1] mid-period at count 100 of the div-1 instance.
        run((100 - k[0] % 255 + 255) % 255);
        duty[C + 1] = 8'hC0;
        run(2 * 765);

        // Period length and 1-step pulse width on the div-3 instance.
        seen = 1'b0;
        for (int i = 0; i < 800 && !seen; i++) begin
            tick();
            if (ps3) seen = 1'b1;
        end
        check("ps3_first_seen", seen, 1'b1);
        seen = 1'b0;
        cnt_t = 0;
        high_t = 0;
        for (int i = 0; i < 800 && !seen; i++) begin
            tick();
            cnt_t++;
            if (r3[1]) high_t++;
            if (ps3) seen = 1'b1;
        end
        check("ps3_period_clocks", cnt_t, 765);
`ifndef LED_PWM_FADE_EN
        check("r3_1_duty1_high_clocks", high_t, 3);
`endif

        // High time of red[0] = 0x80 over one div-1 period.
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (ps1) seen = 1'b1;
        end
        check("ps1_seen", seen, 1'b1);
        high_t = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (r1[0]) high_t++;
        end
`ifndef LED_PWM_FADE_EN
        check("r1_0_high_clocks", high_t, 128);
`endif

        // Random duty changes at random times.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < 4; j++) duty[$urandom_range(0, N - 1)] = int'($urandom_range(0, 255));
            run(int'($urandom_range(100, 900)));
        end

        // One-clock reset at count 50 with every duty at full scale.
        for (int i = 0; i < N; i++) duty[i] = 8'hFF;
        run(765);
        run((50 - k[0] % 255 + 255) % 255);
        srst_n = 1'b0;
        tick();
        srst_n = 1'b1;
        run(2 * 765 + 10);

`ifdef LED_PWM_FADE_EN
        // Fade ramp on blue[0]: up to 4 then back to 0.
        for (int i = 0; i < N; i++) duty[i] = 0;
        run(5 * 765);
        duty[2*C] = 8'h04;
        run(5 * 765);
        duty[2*C] = 8'h00;
        run(5 * 765);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
